// File: rtl/jt10_adpcm_mix_if.sv
// Sample/strobe bundle between the ADPCM-A gain stage, the channel mixer and the output mixer.
interface jt10_adpcm_mix_if;
  logic               cen;
  logic [5:0]         cur_ch;
  logic               valid;
  logic [5:0]         ch_on;
  logic [1:0]         lr;
  logic signed [15:0] pcm_in;
  logic signed [15:0] pcm_left;
  logic signed [15:0] pcm_right;
  logic               snd_sample;

  modport master (
    output cen, cur_ch, valid, ch_on, lr, pcm_in,
    input  pcm_left, pcm_right, snd_sample
  );

  modport slave (
    input  cen, cur_ch, valid, ch_on, lr, pcm_in,
    output pcm_left, pcm_right, snd_sample
  );
endinterface

// File: rtl/jt10_adpcm_mix.sv
// ADPCM-A channel mixer: accumulates six held channel samples per round into saturated
// stereo PCM with a one-cen strobe at round end.
module jt10_adpcm_mix (
  input  logic            clk,
  input  logic            rst_n,
  jt10_adpcm_mix_if.slave mix_io
);

  logic signed [15:0] hold_q    [6];
  logic signed [15:0] hold_d    [6];
  logic [1:0]         hold_lr_q [6];
  logic [1:0]         hold_lr_d [6];
  logic signed [18:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [15:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic               snd_q, snd_d;

  logic               slot_ok;
  logic [2:0]         slot;
  logic signed [15:0] smp;
  logic [1:0]         smp_lr;
  logic signed [18:0] cl, cr, sum_l, sum_r;

  function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
    if (v > 19'sd32767) begin
      return 16'sh7fff;
    end else if (v < -19'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // A zero or multi-hot slot vector makes the whole cen tick a no-op.
  always_comb begin
    slot_ok = (mix_io.cur_ch != 6'd0) && ((mix_io.cur_ch & (mix_io.cur_ch - 6'd1)) == 6'd0);
    slot    = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (mix_io.cur_ch[i]) slot = 3'(i);
    end
  end

  always_comb begin
    hold_d    = hold_q;
    hold_lr_d = hold_lr_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    pcm_l_d   = pcm_l_q;
    pcm_r_d   = pcm_r_q;
    snd_d     = snd_q;
    smp       = '0;
    smp_lr    = 2'b00;

    if (!mix_io.ch_on[slot]) begin
      hold_d[slot]    = '0;
      hold_lr_d[slot] = 2'b00;
    end else if (mix_io.valid) begin
      smp             = mix_io.pcm_in;
      smp_lr          = mix_io.lr;
      hold_d[slot]    = mix_io.pcm_in;
      hold_lr_d[slot] = mix_io.lr;
    end else begin
      smp    = hold_q[slot];
      smp_lr = hold_lr_q[slot];
    end

    cl    = smp_lr[1] ? 19'(smp) : 19'sd0;
    cr    = smp_lr[0] ? 19'(smp) : 19'sd0;
    sum_l = acc_l_q + cl;
    sum_r = acc_r_q + cr;

    if (mix_io.cen) begin
      snd_d = 1'b0;
      if (!slot_ok) begin
        hold_d    = hold_q;
        hold_lr_d = hold_lr_q;
      end else if (slot == 3'd5) begin
        pcm_l_d = sat16(sum_l);
        pcm_r_d = sat16(sum_r);
        acc_l_d = '0;
        acc_r_d = '0;
        snd_d   = 1'b1;
      end else begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
      end
    end else begin
      hold_d    = hold_q;
      hold_lr_d = hold_lr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        hold_q[i]    <= '0;
        hold_lr_q[i] <= 2'b00;
      end
      acc_l_q <= '0;
      acc_r_q <= '0;
      pcm_l_q <= '0;
      pcm_r_q <= '0;
      snd_q   <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      hold_lr_q <= hold_lr_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      pcm_l_q   <= pcm_l_d;
      pcm_r_q   <= pcm_r_d;
      snd_q     <= snd_d;
    end
  end

  assign mix_io.pcm_left   = pcm_l_q;
  assign mix_io.pcm_right  = pcm_r_q;
  assign mix_io.snd_sample = snd_q;

endmodule

// File: doc/jt10_adpcm_mix.md
# jt10_adpcm_mix

Sums the six ADPCM-A channel samples produced by the attenuation stage into one left and one right 16-bit sample per channel round. It sits directly downstream of the ADPCM-A gain stage and consumes its attenuated sample and L/R enable bits. It keeps a per-channel hold register, so a channel contributes its last valid sample every round. It delivers saturated stereo PCM plus a sample strobe to the YM2610 output mixer.

## Interface
- No parameters.
- rst_n  input  1  asynchronous reset, active low
- clk  input  1  CPU clock
- cen  input  1  clock enable (666 kHz); all state changes only when cen=1
- cur_ch  input  6  one-hot pipeline slot, rotates bit0→bit5 on every cen
- valid  input  1  pcm_in/lr carry a fresh attenuated sample for the cur_ch channel this cen
- ch_on  input  6  per-channel enable; a 0 bit forces that channel silent and clears its hold
- lr  input  2  {left,right} enable for the current sample, from the gain stage
- pcm_in  input  16 signed  attenuated channel sample
- pcm_left  output  16 signed  mixed left sample
- pcm_right  output  16 signed  mixed right sample
- snd_sample  output  1  high for the cen period following a round completion

## Operation
- State:
  - hold[0..5] (16-bit signed) and hold_lr[0..5] (2-bit) per channel.
  - acc_l, acc_r: 19-bit signed accumulators (worst case ±6·32768 fits).
- Slot index k = position of the set bit in cur_ch. If cur_ch is not one-hot (zero or multiple bits), the cycle is a no-op: holds, accumulators and outputs unchanged; snd_sample <= 0.
- Per cen with a valid slot k:
  - Select the sample:
    - ch_on[k]=0 → s=0, sl=2'b00; hold[k]<=0, hold_lr[k]<=0.
    - else if valid → s=pcm_in, sl=lr; hold[k]<=pcm_in, hold_lr[k]<=lr.
    - else → s=hold[k], sl=hold_lr[k].
  - Form the contributions: cl = sl[1] ? sext(s) : 0; cr = sl[0] ? sext(s) : 0.
  - If k≠5: acc_l<=acc_l+cl, acc_r<=acc_r+cr; snd_sample<=0.
  - If k=5 (round end):
    - pcm_left<=sat16(acc_l+cl), pcm_right<=sat16(acc_r+cr).
    - acc_l<=0, acc_r<=0.
    - snd_sample<=1.
- sat16: values >32767 give 32767; values <−32768 give −32768; otherwise truncate to 16 bits.
- A round that starts mid-stream after reset (first slot seen ≠0) still closes at slot 5. The partial sum is output as-is.
- A valid sample on slot k updates the output in the same round as that slot.

## Timing
- Reset values: pcm_left=0, pcm_right=0, snd_sample=0, all holds, hold_lr and accumulators 0.
- All outputs are registered and change only on clk edges with cen=1.
- Latency: a sample at slot k appears in pcm_left/right at the slot-5 cen edge of the same round. That is (5−k) cen ticks later, 0 for k=5.
- snd_sample is 1 from the slot-5 cen edge until the next cen edge. It occurs exactly once per 6 cen ticks under normal rotation.
- Simultaneous events:
  - valid with ch_on[k]=0: ch_on wins; the sample is discarded.
  - ch_on 1→0 on a slot: the channel is silent from that slot onward.
  - ch_on 0→1: the channel contributes 0 until its first valid.
- Reset asserted mid-round clears everything immediately (async). No partial output is emitted.

## Test plan
- Reset: hold rst_n low, toggle cen → pcm_left=pcm_right=0, snd_sample=0. Release and run one round with no valid → outputs 0, one snd_sample pulse per 6 cen.
- Single channel: slot 2, valid, pcm_in=1000, lr=2'b10, ch_on=6'h3F → pcm_left=1000, pcm_right=0 at slot-5 edge. The next rounds with no valid keep 1000 (hold).
- Sum and stereo routing, one round:
  - Inputs: ch0=+5000 lr=11; ch1=−2000 lr=01; ch3=+300 lr=10.
  - Expected: pcm_left=5300, pcm_right=3000.
- Saturation:
  - All six channels valid at +20000, lr=11 → both outputs 32767.
  - All six at −20000 → both −32768.
- ch_on gating: channel 4 held at 7000. Clear ch_on[4] → next round output drops by 7000. Re-set ch_on[4] without valid → still 0 until a new valid.
- Bad slot and reset: cur_ch=6'b000000 or 6'b000011 for one cen → no state change, no strobe. Assert rst_n low at slot 3 → outputs 0 immediately, and the next round sums only post-reset samples.
